as_regfile: RTL and testbench
=============================

Name: as_regfile

Overview:
- Integer register file for the RV64I core: 2 asynchronous read ports, 1 synchronous write port, 32 x 64-bit registers.
- Register x0 is hardwired to zero.
- Sits between decode (read operands rs1/rs2) and writeback (rd).

Parameters:
- XLEN, 64, data width of each register and of the read/write data ports.
- AW, 5, register address width; register count NREGS = 2**AW (32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  input  1  write enable for the write port.
- raddr01  input  AW  read port 1 address (rs1).
- raddr02  input  AW  read port 2 address (rs2).
- waddr01  input  AW  write port address (rd).
- wdata01  input  XLEN  write data.
- rdata01  output  XLEN  read port 1 data.
- rdata02  output  XLEN  read port 2 data.

Behaviour:
- Storage: NREGS entries of XLEN bits; entry 0 is not physically writable and always reads as 0.
- Reset (already decided): one clock; reset is synchronous and active-high.
  - Rising edge of clk with rst=1 clears entries 1..NREGS-1 to 0.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset mid-operation takes effect at that edge only; no other state exists.
- Write:
  - On a rising edge with rst=0, we=1 and waddr01!=0, the entry at waddr01 takes wdata01.
  - we=0 or waddr01=0: no state change.
  - Write latency 1 cycle: new value is visible on read ports after that edge.
- Read:
  - Purely combinational. rdata0N = 0 when raddr0N==0, otherwise the entry at raddr0N.
  - Both ports are independent; the same address on both ports returns identical data.
- Same-cycle read of the address being written, without the bypass feature: returns the old value until the edge, then the new value.
- Outputs after reset: rdata01 = rdata02 = 0 for every address.
- No X propagation: all entries are defined after the first reset edge.
- Behaviour before the first reset edge is undefined, except that address 0 reads 0.
- All address values 0..NREGS-1 are legal; there is no out-of-range case.

Optional Feature:
- Macro AS_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If we=1, rst=0, waddr01!=0 and raddr0N==waddr01, then rdata0N = wdata01 combinationally in the same cycle.
  - Address 0 still reads 0.
  - Forwarding is applied per port independently.
- Undefined: no forwarding; reads always reflect stored contents (behaviour above).
- Stored state and write timing are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 edges, release, all addresses 0 -> rdata01=rdata02=0 for raddr 0, 1 and 31.
- x0 protection: we=1, waddr01=0, wdata01=64'hdeadbeefdeadbeef, one edge, we=0, raddr01=raddr02=0 -> both read 0.
- Write/read port 1: we=1, waddr01=1, wdata01=64'hdeadbeefdeadbeef, edge, we=0, raddr01=1, raddr02=0 -> rdata01=64'hdeadbeefdeadbeef, rdata02=0.
- Write/read port 2: we=1, waddr01=2, wdata01=64'hcafebeefbeefcafe, edge, raddr01=0, raddr02=2 -> rdata01=0, rdata02=64'hcafebeefbeefcafe; x1 still reads 64'hdeadbeefdeadbeef.
- we=0 and reset priority:
  - we=0, waddr01=3, wdata01=64'h1234, edge -> x3 reads 0.
  - rst=1 with we=1, waddr01=1, wdata01=64'h5555, edge -> x1 and x2 read 0.
- Bypass (AS_REGFILE_BYPASS_EN defined): we=1, waddr01=5, wdata01=64'hfeed, raddr01=5 before the edge -> rdata01=64'hfeed. Without the macro, rdata01=0 before the edge and 64'hfeed after.

Source files
------------

// File: rtl/as_regfile.sv
// as_regfile: RV64I integer register file, 32 x 64-bit, 2 async read ports, 1 sync write port, x0 hardwired to zero.
// Define AS_REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module as_regfile #(
  parameter int XLEN = 64,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   raddr01,
  input  logic [AW-1:0]   raddr02,
  input  logic [AW-1:0]   waddr01,
  input  logic [XLEN-1:0] wdata01,
  output logic [XLEN-1:0] rdata01,
  output logic [XLEN-1:0] rdata02
);
  localparam int NREGS = 2**AW;
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic wr;
  assign wr = we && !rst && waddr01 != '0;
  always_ff @(posedge clk)
    if (rst) for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    else if (wr) regs[waddr01] <= wdata01;
`ifdef AS_REGFILE_BYPASS_EN
  always_comb begin
    rdata01 = raddr01 == '0 ? '0 : (wr && raddr01 == waddr01) ? wdata01 : regs[raddr01];
    rdata02 = raddr02 == '0 ? '0 : (wr && raddr02 == waddr01) ? wdata01 : regs[raddr02];
  end
`else
  always_comb begin
    rdata01 = raddr01 == '0 ? '0 : regs[raddr01];
    rdata02 = raddr02 == '0 ? '0 : regs[raddr02];
  end
`endif
endmodule

// File: tb/tb_as_regfile.sv
// tb_as_regfile: directed self-checking bench for as_regfile (both builds).
module tb_as_regfile;
  logic clk = 0, rst = 1, we = 0;
  logic [4:0] raddr01 = 0, raddr02 = 0, waddr01 = 0;
  logic [63:0] wdata01 = 0, rdata01, rdata02;
  int tests = 0, fails = 0;

  as_regfile dut (
    .clk(clk), .rst(rst), .we(we),
    .raddr01(raddr01), .raddr02(raddr02), .waddr01(waddr01),
    .wdata01(wdata01), .rdata01(rdata01), .rdata02(rdata02)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    raddr01 = a1;
    raddr02 = a2;
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    rd(0, 0);   chk("rst_p1_x0", rdata01, 0);  chk("rst_p2_x0", rdata02, 0);
    rd(1, 1);   chk("rst_p1_x1", rdata01, 0);  chk("rst_p2_x1", rdata02, 0);
    rd(31, 31); chk("rst_p1_x31", rdata01, 0); chk("rst_p2_x31", rdata02, 0);

    we = 1; waddr01 = 0; wdata01 = 64'hdeadbeefdeadbeef;
    tick(); we = 0;
    rd(0, 0); chk("x0_p1", rdata01, 0); chk("x0_p2", rdata02, 0);

    we = 1; waddr01 = 1; wdata01 = 64'hdeadbeefdeadbeef;
    tick(); we = 0;
    rd(1, 0); chk("wr1_p1", rdata01, 64'hdeadbeefdeadbeef); chk("wr1_p2_x0", rdata02, 0);

    we = 1; waddr01 = 2; wdata01 = 64'hcafebeefbeefcafe;
    tick(); we = 0;
    rd(0, 2); chk("wr2_p1_x0", rdata01, 0); chk("wr2_p2", rdata02, 64'hcafebeefbeefcafe);
    rd(1, 2); chk("wr2_x1_kept", rdata01, 64'hdeadbeefdeadbeef);

    we = 1; waddr01 = 31; wdata01 = 64'ha5a5a5a55a5a5a5a;
    tick(); we = 0;
    rd(31, 31); chk("x31_p1", rdata01, 64'ha5a5a5a55a5a5a5a); chk("x31_p2", rdata02, 64'ha5a5a5a55a5a5a5a);

    we = 0; waddr01 = 3; wdata01 = 64'h1234;
    tick();
    rd(3, 3); chk("we0_x3", rdata01, 0);

    we = 1; waddr01 = 5; wdata01 = 64'hfeed;
    rd(5, 6);
`ifdef AS_REGFILE_BYPASS_EN
    chk("byp_p1_pre", rdata01, 64'hfeed);
`else
    chk("byp_p1_pre", rdata01, 0);
`endif
    chk("byp_p2_other", rdata02, 0);
    tick(); we = 0;
    rd(5, 5); chk("byp_p1_post", rdata01, 64'hfeed); chk("byp_p2_post", rdata02, 64'hfeed);

    we = 1; waddr01 = 6; wdata01 = 64'hbeef;
    rd(0, 6);
`ifdef AS_REGFILE_BYPASS_EN
    chk("byp_p2_pre", rdata02, 64'hbeef);
`else
    chk("byp_p2_pre", rdata02, 0);
`endif
    chk("byp_p1_x0", rdata01, 0);
    tick(); we = 0;

    rst = 1; we = 1; waddr01 = 1; wdata01 = 64'h5555;
    rd(1, 2); chk("rstpri_pre_x1", rdata01, 64'hdeadbeefdeadbeef);
    tick(); rst = 0; we = 0;
    rd(1, 2);   chk("rstpri_x1", rdata01, 0); chk("rstpri_x2", rdata02, 0);
    rd(31, 5);  chk("rstpri_x31", rdata01, 0); chk("rstpri_x5", rdata02, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
